tt_capture_checker: RTL and testbench



---
 rtl/tt_pkg.sv | 24 ++
 rtl/tt_settle_timer.sv | 27 ++
 rtl/tt_capture_checker.sv | 169 ++++++++++++++++
 tb/tb_tt_capture_checker.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table capture checker.
package tt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_VEC,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } tt_state_e;

  localparam int TT_SETTLE_DEF  = 4;
  localparam int TT_TIMEOUT_DEF = 1024;

  function automatic int tt_popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter with zero flag; holds at zero until reloaded.
module tt_settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/tt_capture_checker.sv
// Captures a DUT truth table vector by vector and compares it with an expected table.
// Optional watchdog on idle WAIT_VEC cycles is built only when TT_TIMEOUT_EN is defined.
module tt_capture_checker
  import tt_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int SETTLE  = TT_SETTLE_DEF,
  parameter int TIMEOUT = TT_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 vecValid,
  input  logic [N_IN-1:0]      vecIdx,
  output logic                 vecReady,
  input  logic                 dutOut,
  input  logic [(1<<N_IN)-1:0] expTable,
  output logic [(1<<N_IN)-1:0] capTable,
  output logic [(1<<N_IN)-1:0] errMask,
  output logic [N_IN:0]        errCount,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout
);

  localparam int DEPTH = 1 << N_IN;
  localparam int SW    = $clog2(SETTLE + 1);

  tt_state_e        state_q;
  logic [N_IN-1:0]  idx_q;
  logic [DEPTH-1:0] cap_q, err_q, seen_q;
  logic [N_IN:0]    err_cnt_q;
  logic             vec_ready_q, busy_q, done_q, pass_q, timeout_q;

  logic             hs, start_ok, sample_err, all_seen;
  logic             settle_load, settle_dec, settle_zero, wd_expire;
  logic [DEPTH-1:0] idx_onehot, seen_d;
  logic [N_IN:0]    err_cnt_d;

  assign hs          = vecValid & vec_ready_q;
  assign start_ok    = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
  assign sample_err  = dutOut ^ expTable[idx_q];
  assign idx_onehot  = DEPTH'(1) << idx_q;
  assign seen_d      = seen_q | idx_onehot;
  assign all_seen    = &seen_d;
  assign settle_load = (state_q == ST_WAIT_VEC) & hs;
  assign settle_dec  = (state_q == ST_SETTLE);

  // Count follows the error bit of the index being overwritten, so duplicates stay consistent.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (sample_err && !err_q[idx_q]) begin
      err_cnt_d = err_cnt_q + (N_IN+1)'(1);
    end else if (!sample_err && err_q[idx_q]) begin
      err_cnt_d = err_cnt_q - (N_IN+1)'(1);
    end
  end

  tt_settle_timer #(.W(SW)) u_settle (
    .clk        (clk),
    .rst        (rst),
    .load_i     (settle_load),
    .load_val_i (SW'(SETTLE - 1)),
    .dec_i      (settle_dec),
    .zero_o     (settle_zero)
  );

`ifdef TT_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic wd_load, wd_dec, wd_zero;

  // Reloaded on every entry into WAIT_VEC; an accepted vector leaves the state, which clears it.
  assign wd_load   = start_ok | ((state_q == ST_SAMPLE) & ~all_seen);
  assign wd_dec    = (state_q == ST_WAIT_VEC) & ~hs;
  assign wd_expire = wd_dec & wd_zero;

  tt_settle_timer #(.W(WW)) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wd_load),
    .load_val_i (WW'(TIMEOUT - 1)),
    .dec_i      (wd_dec),
    .zero_o     (wd_zero)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT;
  assign wd_expire          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cap_q       <= '0;
      err_q       <= '0;
      seen_q      <= '0;
      err_cnt_q   <= '0;
      vec_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            cap_q       <= '0;
            err_q       <= '0;
            seen_q      <= '0;
            err_cnt_q   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b1;
            vec_ready_q <= 1'b1;
            state_q     <= ST_WAIT_VEC;
          end
        end
        ST_WAIT_VEC: begin
          if (hs) begin
            idx_q       <= vecIdx;
            vec_ready_q <= 1'b0;
            state_q     <= ST_SETTLE;
          end else if (wd_expire) begin
            vec_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b1;
            state_q     <= ST_DONE;
          end
        end
        ST_SETTLE: begin
          if (settle_zero) begin
            state_q <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          cap_q[idx_q] <= dutOut;
          err_q[idx_q] <= sample_err;
          err_cnt_q    <= err_cnt_d;
          seen_q       <= seen_d;
          if (all_seen) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == '0);
            state_q <= ST_DONE;
          end else begin
            vec_ready_q <= 1'b1;
            state_q     <= ST_WAIT_VEC;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign vecReady = vec_ready_q;
  assign capTable = cap_q;
  assign errMask  = err_q;
  assign errCount = err_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_tt_capture_checker.sv
// Randomized self-checking bench for tt_capture_checker against a table-level reference model.
module tb_tt_capture_checker;
  import tt_pkg::*;

  localparam int N_IN    = 3;
  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst, start, vecValid, dutOut;
  logic [2:0] vecIdx;
  logic [7:0] expTable;
  logic       vecReady, busy, done, pass, timeout;
  logic [7:0] capTable, errMask;
  logic [3:0] errCount;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  // Reference model: last value returned per index and which indices were seen this run.
  logic [7:0] m_cap, m_seen;

  tt_capture_checker #(.N_IN(N_IN), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .vecValid(vecValid), .vecIdx(vecIdx),
    .vecReady(vecReady), .dutOut(dutOut), .expTable(expTable), .capTable(capTable),
    .errMask(errMask), .errCount(errCount), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(output int c0);
    start = 1'b1;
    c0    = cyc;
    tick();
    start  = 1'b0;
    m_cap  = '0;
    m_seen = '0;
    check_eq("busy_after_start", busy, 1);
  endtask

  task automatic send_vec(input logic [2:0] idx, input logic val, input bit glitch, input int gap);
    int n;
    repeat (gap) tick();
    n = 0;
    while (!vecReady && n < 100) begin
      tick();
      n++;
    end
    check_eq("vec_ready", vecReady, 1);
    vecIdx   = idx;
    vecValid = 1'b1;
    dutOut   = glitch ? ~val : val;
    tick();
    vecValid = 1'b0;
    check_eq("ready_drop", vecReady, 0);
    if (glitch) begin
      repeat (SETTLE - 1) @(posedge clk);
      #1;
      dutOut = val;
    end
    m_cap[idx]  = val;
    m_seen[idx] = 1'b1;
    $display("vec idx=%0d val=%0b glitch=%0b", idx, val, glitch);
  endtask

  task automatic finish_run(input string tag, output int done_cyc);
    int n;
    logic [7:0] exp_mask;
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    done_cyc = cyc;
    exp_mask = (m_cap ^ expTable) & m_seen;
    check_eq({tag, "_done"}, done, 1);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_cap"}, capTable, m_cap);
    check_eq({tag, "_mask"}, errMask, exp_mask);
    check_eq({tag, "_count"}, errCount, tt_popcount(64'(exp_mask)));
    check_eq({tag, "_pass"}, pass, (m_seen == 8'hFF) && (exp_mask == 0));
    check_eq({tag, "_timeout"}, timeout, 0);
    $display("run %s exp=%02h cap=%02h mask=%02h count=%0d pass=%0b", tag, expTable,
             capTable, errMask, errCount, pass);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ready"}, vecReady, 0);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_pass"}, pass, 0);
    check_eq({tag, "_timeout"}, timeout, 0);
    check_eq({tag, "_cap"}, capTable, 0);
    check_eq({tag, "_mask"}, errMask, 0);
    check_eq({tag, "_count"}, errCount, 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    vecValid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic golden_run(input string tag, input bit check_latency);
    int c0, cd;
    expTable = 8'h2E;
    start_run(c0);
    for (int i = 0; i < 8; i++) send_vec(3'(i), expTable[i], 1'b0, 0);
    finish_run(tag, cd);
    check_eq({tag, "_mask_const"}, errMask, 8'h00);
    if (check_latency) check_eq({tag, "_latency"}, cd - c0, 1 + 8 * (SETTLE + 2));
  endtask

  initial begin
    int c0, cd, n;
    logic [2:0] idx_q[$];
    logic [7:0] fault;
    logic [3:0] order_idx [9];
    logic [2:0] perm [8];

    rst = 1'b1; start = 1'b0; vecValid = 1'b0; vecIdx = '0; dutOut = 1'b0; expTable = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_all_zero("reset");

    // Golden run, including done latency from the start cycle.
    golden_run("golden", 1'b1);

    // Injected fault at index 5.
    expTable = 8'h2E;
    start_run(c0);
    for (int i = 0; i < 8; i++) send_vec(3'(i), expTable[i] ^ (i == 5), 1'b0, 0);
    finish_run("fault5", cd);
    check_eq("fault5_mask_const", errMask, 8'h20);
    check_eq("fault5_count_const", errCount, 1);

    // Out-of-order with a duplicate that corrects an earlier wrong value; stray start mid-run.
    order_idx = '{7, 3, 3, 0, 6, 1, 5, 2, 4};
    start_run(c0);
    for (int i = 0; i < 9; i++) begin
      send_vec(order_idx[i][2:0], expTable[order_idx[i][2:0]] ^ (i == 1), 1'b0, 0);
      if (i == 1) check_eq("dup_first_err", errCount, 0);
      if (i == 3) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    finish_run("order_dup", cd);

    // Settle-window glitches on every vector, random expected table and order.
    expTable = 8'($urandom);
    for (int i = 0; i < 8; i++) perm[i] = 3'(i);
    for (int i = 7; i > 0; i--) begin
      int j;
      logic [2:0] t;
      j = $urandom_range(0, i);
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    start_run(c0);
    for (int i = 0; i < 8; i++) send_vec(perm[i], expTable[perm[i]], 1'b1, 0);
    finish_run("glitch", cd);

    // Random runs: random tables, random indices with duplicates and sparse faults.
    for (int r = 0; r < 6; r++) begin
      expTable = 8'($urandom);
      fault    = 8'($urandom & $urandom & $urandom);
      start_run(c0);
      n = 0;
      while (m_seen != 8'hFF) begin
        logic [2:0] idx;
        logic bad;
        if (n < 20) idx = 3'($urandom_range(0, 7));
        else for (int k = 7; k >= 0; k--) if (!m_seen[k]) idx = 3'(k);
        bad = fault[idx] ^ ($urandom_range(0, 5) == 0);
        send_vec(idx, expTable[idx] ^ bad, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        n++;
      end
      finish_run($sformatf("rand%0d", r), cd);
    end

    // Mid-run reset after four vectors, then a clean run.
    expTable = 8'h2E;
    start_run(c0);
    for (int i = 0; i < 4; i++) send_vec(3'(i), ~expTable[i], 1'b0, 0);
    pulse_reset();
    check_all_zero("midrst");
    golden_run("after_rst", 1'b1);

    // Vectors stop after three accepts.
    start_run(c0);
    for (int i = 0; i < 3; i++) send_vec(3'(i), expTable[i], 1'b0, 0);
`ifdef TT_TIMEOUT_EN
    n = 0;
    while (!vecReady && n < 50) begin tick(); n++; end
    c0 = cyc;
    n = 0;
    while (!timeout && n < 100) begin tick(); n++; end
    check_eq("wd_latency", cyc - c0, TIMEOUT);
    check_eq("wd_timeout", timeout, 1);
    check_eq("wd_done", done, 1);
    check_eq("wd_pass", pass, 0);
    check_eq("wd_busy", busy, 0);
    $display("watchdog timeout=%0b done=%0b pass=%0b", timeout, done, pass);
`else
    repeat (40) tick();
    check_eq("nowd_busy", busy, 1);
    check_eq("nowd_timeout", timeout, 0);
    check_eq("nowd_done", done, 0);
    $display("no watchdog busy=%0b timeout=%0b", busy, timeout);
    pulse_reset();
`endif
    golden_run("final", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
